// File: rtl/clock_enable_scheduler_pkg.sv
// Shared definitions for the clock-enable scheduler: domain FSM encodings,
// domain indices and status field layout.
package clock_enable_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    localparam int NUM_DOM    = 3;
    localparam int DOM_DMA    = 0;
    localparam int DOM_FIR    = 1;
    localparam int DOM_FFT    = 2;
    localparam int ST_FIELD_W = 2;

    // Domain index doubles as status slot: {fft, fir, dma} from MSB to LSB.
    function automatic int status_lsb(input int dom);
        return dom * ST_FIELD_W;
    endfunction

endpackage

// File: rtl/clock_enable_scheduler_domain_power_fsm.sv
// One gated domain: OFF -> WAKE (settle) -> ON <-> DRAIN (idle timeout) -> OFF.
// Enable and ready are decoded from the state register only.
module domain_power_fsm
    import clock_enable_scheduler_pkg::*;
#(
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic   clk_in,
    input  logic   reset_n,
    input  logic   grant,
    input  logic   eff_req,
    input  logic   busy,
    output state_e state,
    output logic   enable,
    output logic   ready
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (grant) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) state_d = ST_ON;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ON: begin
                if (!eff_req && !busy) begin
                    state_d = ST_DRAIN;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ST_DRAIN: begin
                // Renewed activity takes precedence over an expiring timeout.
                if (eff_req || busy) state_d = ST_ON;
                else if (cnt_q == '0) state_d = ST_OFF;
                else                  cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        state  = state_q;
        enable = (state_q != ST_OFF);
        ready  = (state_q == ST_ON) || (state_q == ST_DRAIN);
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Sequences the DMA/FIR/FFT clock-gate enables: one wake at a time,
// DMA first up and last down.
module clock_enable_scheduler
    import clock_enable_scheduler_pkg::*;
#(
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       req_fir,
    input  logic       req_fft,
    input  logic       req_dma,
    input  logic       busy_fir,
    input  logic       busy_fft,
    input  logic       busy_dma,
    output logic       enable_fir,
    output logic       enable_fft,
    output logic       enable_dma,
    output logic       ready_fir,
    output logic       ready_fft,
    output logic       ready_dma,
    output logic       wake_busy,
    output logic [5:0] status
);

    state_e               st [NUM_DOM];
    logic [NUM_DOM-1:0]   eff_req, busy, grant, en, rdy, in_wake;
    logic                 dma_up;

    assign busy[DOM_DMA] = busy_dma;
    assign busy[DOM_FIR] = busy_fir;
    assign busy[DOM_FFT] = busy_fft;

    // DMA stays requested while either consumer is anywhere but OFF.
    assign eff_req[DOM_DMA] = req_dma | req_fir | req_fft |
                              (st[DOM_FIR] != ST_OFF) | (st[DOM_FFT] != ST_OFF);
    assign eff_req[DOM_FIR] = req_fir;
    assign eff_req[DOM_FFT] = req_fft;

    assign dma_up = (st[DOM_DMA] == ST_ON) || (st[DOM_DMA] == ST_DRAIN);

    always_comb begin
        grant = '0;
        if (in_wake == '0) begin
            if (st[DOM_DMA] == ST_OFF && eff_req[DOM_DMA])
                grant[DOM_DMA] = 1'b1;
            else if (dma_up && st[DOM_FIR] == ST_OFF && eff_req[DOM_FIR])
                grant[DOM_FIR] = 1'b1;
            else if (dma_up && st[DOM_FFT] == ST_OFF && eff_req[DOM_FFT])
                grant[DOM_FFT] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
            domain_power_fsm #(
                .WAKE_CYCLES (WAKE_CYCLES),
                .IDLE_CYCLES (IDLE_CYCLES),
                .CNT_W       (CNT_W)
            ) u_fsm (
                .clk_in  (clk_in),
                .reset_n (reset_n),
                .grant   (grant[gi]),
                .eff_req (eff_req[gi]),
                .busy    (busy[gi]),
                .state   (st[gi]),
                .enable  (en[gi]),
                .ready   (rdy[gi])
            );
            assign in_wake[gi] = (st[gi] == ST_WAKE);
            assign status[status_lsb(gi) +: ST_FIELD_W] = st[gi];
        end
    endgenerate

    assign enable_dma = en[DOM_DMA];
    assign enable_fir = en[DOM_FIR];
    assign enable_fft = en[DOM_FFT];
    assign ready_dma  = rdy[DOM_DMA];
    assign ready_fir  = rdy[DOM_FIR];
    assign ready_fft  = rdy[DOM_FFT];
    assign wake_busy  = |in_wake;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed bench for clock_enable_scheduler at default parameters; cycle 0 is
// the cycle in which a stimulus change is applied.
module tb_clock_enable_scheduler;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       req_fir, req_fft, req_dma;
    logic       busy_fir, busy_fft, busy_dma;
    logic       enable_fir, enable_fft, enable_dma;
    logic       ready_fir, ready_fft, ready_dma;
    logic       wake_busy;
    logic [5:0] status;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk_in = ~clk_in;

    clock_enable_scheduler dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .req_fir    (req_fir),
        .req_fft    (req_fft),
        .req_dma    (req_dma),
        .busy_fir   (busy_fir),
        .busy_fft   (busy_fft),
        .busy_dma   (busy_dma),
        .enable_fir (enable_fir),
        .enable_fft (enable_fft),
        .enable_dma (enable_dma),
        .ready_fir  (ready_fir),
        .ready_fft  (ready_fft),
        .ready_dma  (ready_dma),
        .wake_busy  (wake_busy),
        .status     (status)
    );

    wire [12:0] all_o = {status, wake_busy, ready_fft, ready_fir, ready_dma,
                         enable_fft, enable_fir, enable_dma};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic go(input int k);
        while (cyc < k) tick();
    endtask

    function automatic int nwake(input logic [5:0] s);
        int n = 0;
        for (int i = 0; i < 3; i++) if (s[2*i +: 2] == 2'b01) n++;
        return n;
    endfunction

    initial begin
        reset_n = 1'b0;
        {req_fir, req_fft, req_dma}    = 3'b000;
        {busy_fir, busy_fft, busy_dma} = 3'b000;
        #12;
        check("rst_init", 32'(all_o), 32'd0);
        repeat (2) @(posedge clk_in);
        #3 reset_n = 1'b1;
        repeat (4) tick();
        check("idle_after_rst", 32'(all_o), 32'd0);

        // Cold FIR request: DMA wakes first, then FIR.
        cyc = 0; req_fir = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            go(k);
            check("cold_en_dma",  32'(enable_dma), 32'(k >= 1));
            check("cold_rdy_dma", 32'(ready_dma),  32'(k >= 5));
            check("cold_en_fir",  32'(enable_fir), 32'(k >= 6));
            check("cold_rdy_fir", 32'(ready_fir),  32'(k >= 10));
            check("cold_wake_busy", 32'(wake_busy),
                  32'((k >= 1 && k <= 4) || (k >= 6 && k <= 9)));
        end
        check("cold_status", 32'(status), 32'(6'b00_10_10));
        $display("[TB] cold FIR request done");

        // Drain timeout: FIR then DMA gate off.
        cyc = 0; req_fir = 1'b0;
        go(1);  check("drain_fir_c1",  32'(status), 32'(6'b00_11_10));
        go(16); check("drain_fir_c16", 32'(status), 32'(6'b00_11_10));
        go(17); check("drain_fir_off", 32'(status), 32'(6'b00_00_10));
        check("drain_fir_en", 32'(enable_fir), 32'd0);
        go(18); check("drain_dma_c18", 32'(status), 32'(6'b00_00_11));
        go(33); check("drain_dma_c33", 32'(status), 32'(6'b00_00_11));
        go(34); check("drain_all_off", 32'(all_o), 32'd0);
        $display("[TB] drain timeout done");

        // Simultaneous FIR+FFT with DMA up; then reset mid-WAKE.
        cyc = 0; req_dma = 1'b1;
        go(5); check("sim_dma_ready", 32'(ready_dma), 32'd1);
        cyc = 0; req_fir = 1'b1; req_fft = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            go(k);
            check("sim_one_wake", 32'(nwake(status) <= 1), 32'd1);
            if (k == 4) check("sim_c4", 32'(status), 32'(6'b00_01_10));
            if (k == 5) check("sim_c5", 32'(status), 32'(6'b00_10_10));
            if (k == 6) begin
                check("sim_c6", 32'(status), 32'(6'b01_10_10));
                check("sim_en_fft", 32'(enable_fft), 32'd1);
            end
        end
        #2 reset_n = 1'b0;
        #1 check("rst_mid_wake", 32'(all_o), 32'd0);
        {req_fir, req_fft, req_dma} = 3'b000;
        @(posedge clk_in);
        #3 reset_n = 1'b1;
        tick(); tick();
        check("rst_wake_release", 32'(all_o), 32'd0);
        $display("[TB] simultaneous request + reset mid-WAKE done");

        // Drain reactivation via busy pulse at counter 5.
        cyc = 0; req_fir = 1'b1;
        go(10); check("react_rdy_fir", 32'(ready_fir), 32'd1);
        cyc = 0; req_fir = 1'b0;
        go(11); check("react_c11", 32'(status), 32'(6'b00_11_10));
        busy_fir = 1'b1;
        go(12); check("react_on", 32'(status), 32'(6'b00_10_10));
        busy_fir = 1'b0;
        go(13); check("react_c13", 32'(status), 32'(6'b00_11_10));
        go(28); check("react_c28", 32'(status), 32'(6'b00_11_10));
        go(29); check("react_fir_off", 32'(status), 32'(6'b00_00_10));
        go(45); check("react_dma_c45", 32'(status), 32'(6'b00_00_11));
        go(46); check("react_all_off", 32'(all_o), 32'd0);
        $display("[TB] drain reactivation done");

        // One-cycle DMA request still completes the full wake.
        cyc = 0; req_dma = 1'b1;
        go(1); req_dma = 1'b0;
        check("pulse_c1", 32'(status), 32'(6'b00_00_01));
        go(4);  check("pulse_c4", 32'(status), 32'(6'b00_00_01));
        go(5);  check("pulse_c5", 32'(status), 32'(6'b00_00_10));
        check("pulse_rdy", 32'(ready_dma), 32'd1);
        go(6);  check("pulse_c6", 32'(status), 32'(6'b00_00_11));
        go(21); check("pulse_c21", 32'(status), 32'(6'b00_00_11));
        go(22); check("pulse_off", 32'(all_o), 32'd0);
        $display("[TB] request drop in WAKE done");

        // Busy alone never wakes a domain.
        cyc = 0; {busy_fir, busy_fft, busy_dma} = 3'b111;
        go(5); check("busy_off", 32'(all_o), 32'd0);
        {busy_fir, busy_fft, busy_dma} = 3'b000;
        $display("[TB] busy while OFF done");

        // Reset with DMA and FIR both ON.
        cyc = 0; req_fir = 1'b1;
        go(12); check("pre_rst_on", 32'(status), 32'(6'b00_10_10));
        #2 reset_n = 1'b0;
        #1 check("rst_mid_on", 32'(all_o), 32'd0);
        req_fir = 1'b0;
        tick();
        #3 reset_n = 1'b1;
        tick(); tick();
        check("rst_on_release", 32'(all_o), 32'd0);
        $display("[TB] reset mid-ON done");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Per-domain power sequencer that drives the enable_fir / enable_fft / enable_dma inputs of the clock-gating block.
- Brings each gated domain up on demand and waits a settle time before reporting it ready. Holds the domain through an idle timeout and gates it off when unused.
- Only one domain may be waking at a time, to limit inrush. DMA is always up before FIR/FFT and stays up while either is powered.

Parameters:
- WAKE_CYCLES, 4, clk_in cycles a domain stays in WAKE before ready (>=1)
- IDLE_CYCLES, 16, idle clk_in cycles in DRAIN before gating off (>=1)
- CNT_W, 8, per-domain counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES)-1

Ports:
- clk_in  in  1  system clock (undivided)
- reset_n  in  1  asynchronous, active-low reset
- req_fir / req_fft / req_dma  in  1 each  work pending for the domain
- busy_fir / busy_fft / busy_dma  in  1 each  domain still processing (synchronous to clk_in)
- enable_fir / enable_fft / enable_dma  out  1 each  to the clock-gating enables; registered
- ready_fir / ready_fft / ready_dma  out  1 each  domain clocked and settled; registered
- wake_busy  out  1  some domain is in WAKE
- status  out  6  {st_fft[1:0], st_fir[1:0], st_dma[1:0]}

Behaviour:
- Per-domain FSM states: OFF=2'b00, WAKE=2'b01, ON=2'b10, DRAIN=2'b11.
  - enable=1 in WAKE, ON and DRAIN.
  - ready=1 in ON and DRAIN.
  - Both are decoded from the registered state, so there is no combinational path from inputs.
- Reset (async, reset_n=0): all FSMs go to OFF, counters to 0, and every output goes to 0 immediately. On release, FSMs start in OFF.
- Effective requests:
  - eff_req_dma = req_dma | req_fir | req_fft | (st_fir!=OFF) | (st_fft!=OFF)
  - eff_req_fir = req_fir; eff_req_fft = req_fft
- Wake arbiter (combinational, evaluated on current state):
  - Grants at most one domain per cycle; the domain must be in OFF with eff_req=1.
  - No grant while any domain is in WAKE.
  - Fixed priority DMA > FIR > FFT.
  - FIR/FFT are eligible only when st_dma is ON or DRAIN.
- OFF -> WAKE on grant. Counter loads WAKE_CYCLES-1.
- WAKE:
  - Counter decrements each cycle; at 0, next state is ON.
  - Total WAKE_CYCLES cycles in WAKE.
  - Requests dropping during WAKE do not abort it.
- ON -> DRAIN when eff_req=0 and busy=0. Counter loads IDLE_CYCLES-1.
- DRAIN:
  - If eff_req=1 or busy=1, return to ON in the next cycle.
  - Otherwise the counter decrements; at 0 with still idle, go to OFF.
  - Reactivation wins over timeout in the same cycle.
- busy=1 while OFF has no effect; only req wakes a domain.
- DMA cannot leave ON/DRAIN while FIR or FFT is not OFF, because its eff_req stays high. DMA therefore gates off last.
- Latency:
  - Grant in cycle t -> enable high at t+1, ready high at t+1+WAKE_CYCLES.
  - With a cold DMA and an FIR-only request, ready_fir = 2*WAKE_CYCLES+2 cycles after req_fir rises.
- Simultaneous FIR and FFT requests: FIR wakes first, FFT is granted in the cycle FIR reaches ON.
- wake_busy = OR of (state==WAKE) over the three domains, registered-state based.

Decomposition:
- Shared package: FSM state encodings (ST_OFF, ST_WAKE, ST_ON, ST_DRAIN) and status field offsets.
- One sub-module, domain_power_fsm, holds the FSM and counter. Its ports are clk_in, reset_n, grant, eff_req, busy, state, enable, ready.
- Top level instantiates it three times and adds the eff_req logic, the wake arbiter and the status packing.

Test Plan:
- Reset: assert reset_n=0 mid-WAKE and mid-ON -> all enables, readies and status go to 0 asynchronously. After release, everything stays OFF with no requests.
- Cold FIR request (defaults), req_fir=1 at cycle 0:
  - enable_dma=1 at cycle 1, ready_dma=1 at cycle 5.
  - enable_fir=1 at cycle 6, ready_fir=1 at cycle 10.
  - wake_busy high in cycles 1-4 and 6-9.
- Simultaneous req_fir=req_fft=1 with DMA already ON:
  - FIR WAKE in cycles 1-4, FFT granted at cycle 5, enable_fft=1 at cycle 6.
  - Never two domains in WAKE together.
- Drain timeout: FIR ON, drop req_fir and busy_fir at cycle 0:
  - DRAIN in cycles 1-16, OFF at cycle 17.
  - DMA then drains and turns off 16 cycles later, with req_dma=0.
- Drain reactivation: during FIR DRAIN (counter=5), pulse busy_fir=1 -> back to ON the next cycle. A later drop restarts the full 16-cycle count.
- Request drop in WAKE: req_dma pulsed for 1 cycle -> DMA still completes 4 WAKE cycles, enters ON, then DRAIN and OFF after 16 more idle cycles.
